// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, register write-back,
// WB->ID operand bypass and a retired-instruction counter.
module mem_wb_stage #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              mem_valid,
   input  logic              mem_reg_write,
   input  logic              mem_mem_to_reg,
   input  logic [1:0]        mem_load_size,
   input  logic              mem_load_unsigned,
   input  logic [DATA_W-1:0] mem_alu_result,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [ADDR_W-1:0] mem_addr_w,
   input  logic [ADDR_W-1:0] id_addr_r1,
   input  logic [ADDR_W-1:0] id_addr_r2,
   input  logic [DATA_W-1:0] id_rf_data_r1,
   input  logic [DATA_W-1:0] id_rf_data_r2,
   output logic              rf_we,
   output logic [ADDR_W-1:0] rf_addr_w,
   output logic [DATA_W-1:0] rf_data_w,
   output logic [DATA_W-1:0] id_data_r1,
   output logic [DATA_W-1:0] id_data_r2,
   output logic [CNT_W-1:0]  retire_count
);

   logic              wb_valid_q;
   logic              wb_reg_write_q;
   logic              wb_mem_to_reg_q;
   logic [1:0]        wb_load_size_q;
   logic              wb_load_unsigned_q;
   logic [DATA_W-1:0] wb_alu_result_q;
   logic [DATA_W-1:0] wb_read_data_q;
   logic [ADDR_W-1:0] wb_addr_w_q;
   logic [CNT_W-1:0]  retire_q;
   logic [CNT_W-1:0]  retire_d;

   logic              capture;
   logic [1:0]        off;
   logic [DATA_W-1:0] byte_shift;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;
   logic              sext;
   logic [DATA_W-1:0] load_ext;

   assign capture  = !flush && !stall;
   assign retire_d = retire_q + CNT_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_valid_q         <= 1'b0;
         wb_reg_write_q     <= 1'b0;
         wb_mem_to_reg_q    <= 1'b0;
         wb_load_size_q     <= 2'b00;
         wb_load_unsigned_q <= 1'b0;
         wb_alu_result_q    <= '0;
         wb_read_data_q     <= '0;
         wb_addr_w_q        <= '0;
         retire_q           <= '0;
      end else begin
         if (flush) begin
            wb_valid_q <= 1'b0;
         end else if (!stall) begin
            wb_valid_q         <= mem_valid;
            wb_reg_write_q     <= mem_reg_write;
            wb_mem_to_reg_q    <= mem_mem_to_reg;
            wb_load_size_q     <= mem_load_size;
            wb_load_unsigned_q <= mem_load_unsigned;
            wb_alu_result_q    <= mem_alu_result;
            wb_read_data_q     <= mem_read_data;
            wb_addr_w_q        <= mem_addr_w;
         end
         if (capture && mem_valid) begin
            retire_q <= retire_d;
         end
      end
   end

   // Little-endian lanes; halfword selection ignores off[0].
   assign off        = wb_alu_result_q[1:0];
   assign byte_shift = wb_read_data_q >> {off, 3'b000};
   assign lane_b     = byte_shift[7:0];
   assign lane_h     = off[1] ? wb_read_data_q[31:16]
                              : wb_read_data_q[15:0];
   assign sext       = !wb_load_unsigned_q;

   always_comb begin
      load_ext = wb_read_data_q;
      unique case (wb_load_size_q)
         2'b00:   load_ext = {{(DATA_W-8){sext & lane_b[7]}}, lane_b};
         2'b01:   load_ext = {{(DATA_W-16){sext & lane_h[15]}}, lane_h};
         default: load_ext = wb_read_data_q;
      endcase
   end

   assign rf_we     = wb_valid_q && wb_reg_write_q && (wb_addr_w_q != '0);
   assign rf_addr_w = wb_addr_w_q;
   assign rf_data_w = wb_mem_to_reg_q ? load_ext : wb_alu_result_q;

   assign id_data_r1 = (rf_we && id_addr_r1 == rf_addr_w) ? rf_data_w
                                                         : id_rf_data_r1;
   assign id_data_r2 = (rf_we && id_addr_r2 == rf_addr_w) ? rf_data_w
                                                         : id_rf_data_r2;

   assign retire_count = retire_q;

endmodule
